// File: rtl/ami_channel_arbiter.sv
// rtl/ami_channel_arbiter.sv - round-robin SimpleDRAM channel arbiter with in-order read tag FIFO
// Tag FIFO depth bounds outstanding reads; disabled requesters have their responses drained.
module ami_channel_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 512,
  parameter int LOG_TAG_D = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_is_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  input  logic [NUM_REQ-1:0]          resp_grant,
  output logic                        ch_req_valid,
  output logic                        ch_req_is_write,
  output logic [ADDR_W-1:0]           ch_req_addr,
  output logic [DATA_W-1:0]           ch_req_data,
  input  logic                        ch_req_grant,
  input  logic                        ch_resp_valid,
  input  logic [DATA_W-1:0]           ch_resp_data,
  output logic                        ch_resp_grant,
  output logic [LOG_TAG_D:0]          outstanding,
  output logic                        err_orphan_resp
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = 1 << LOG_TAG_D;
  localparam logic [TAG_W-1:0] LAST = TAG_W'(NUM_REQ - 1);

  logic [TAG_W-1:0]     rr_ptr;
  logic [TAG_W-1:0]     win;
  logic [TAG_W-1:0]     scan;
  logic                 found;
  logic [NUM_REQ-1:0]   elig;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 push;
  logic                 pop;
  logic [TAG_W-1:0]     tag_mem [DEPTH];
  logic [LOG_TAG_D-1:0] wr_ptr;
  logic [LOG_TAG_D-1:0] rd_ptr;
  logic [TAG_W-1:0]     head;
  logic                 head_en;

  // The occupancy counter doubles as the FIFO count; its MSB set means exactly DEPTH entries.
  assign tag_full  = outstanding[LOG_TAG_D];
  assign tag_empty = (outstanding == '0);
  assign elig      = req_valid & req_enable & (req_is_write | {NUM_REQ{~tag_full}});

  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && elig[scan]) begin
        found = 1'b1;
        win   = scan;
      end
      scan = (scan == LAST) ? '0 : scan + 1'b1;
    end
  end

  assign ch_req_valid    = !rst && found;
  assign ch_req_is_write = req_is_write[win];
  assign ch_req_addr     = req_addr[int'(win)*ADDR_W +: ADDR_W];
  assign ch_req_data     = req_data[int'(win)*DATA_W +: DATA_W];

  always_comb begin
    req_grant = '0;
    if (ch_req_valid && ch_req_grant) req_grant[win] = 1'b1;
  end

  assign push = ch_req_valid && ch_req_grant && !ch_req_is_write;

  assign head    = tag_mem[rd_ptr];
  assign head_en = req_enable[head];

  always_comb begin
    resp_valid = '0;
    if (!rst && ch_resp_valid && !tag_empty && head_en) resp_valid[head] = 1'b1;
  end

  // Responses owed to a disabled requester are accepted and dropped.
  assign ch_resp_grant = !rst && (tag_empty ? ch_resp_valid : (resp_grant[head] || !head_en));
  assign resp_data     = ch_resp_data;
  assign pop           = ch_resp_valid && ch_resp_grant && !tag_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr          <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      outstanding     <= '0;
      err_orphan_resp <= 1'b0;
    end else begin
      if (|req_grant) rr_ptr <= (win == LAST) ? '0 : win + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (ch_resp_valid && tag_empty) err_orphan_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

endmodule

// File: tb/tb_ami_channel_arbiter.sv
// tb/tb_ami_channel_arbiter.sv - directed self-checking bench for ami_channel_arbiter
module tb_ami_channel_arbiter;

  logic          clk;
  logic          rst;
  logic [3:0]    req_enable;
  logic [3:0]    req_valid;
  logic [3:0]    req_is_write;
  logic [255:0]  req_addr;
  logic [2047:0] req_data;
  logic [3:0]    req_grant;
  logic [3:0]    resp_valid;
  logic [511:0]  resp_data;
  logic [3:0]    resp_grant;
  logic          ch_req_valid;
  logic          ch_req_is_write;
  logic [63:0]   ch_req_addr;
  logic [511:0]  ch_req_data;
  logic          ch_req_grant;
  logic          ch_resp_valid;
  logic [511:0]  ch_resp_data;
  logic          ch_resp_grant;
  logic [4:0]    outstanding;
  logic          err_orphan_resp;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int idx0;
  int idx1;

  ami_channel_arbiter dut (
    .clk(clk), .rst(rst),
    .req_enable(req_enable), .req_valid(req_valid), .req_is_write(req_is_write),
    .req_addr(req_addr), .req_data(req_data), .req_grant(req_grant),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_grant(resp_grant),
    .ch_req_valid(ch_req_valid), .ch_req_is_write(ch_req_is_write),
    .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data), .ch_req_grant(ch_req_grant),
    .ch_resp_valid(ch_resp_valid), .ch_resp_data(ch_resp_data), .ch_resp_grant(ch_resp_grant),
    .outstanding(outstanding), .err_orphan_resp(err_orphan_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req_enable = 4'hF; req_valid = 4'b0001; req_is_write = 4'hF;
    req_addr = '0; req_data = '0; resp_grant = '0;
    ch_req_grant = 1'b1; ch_resp_valid = 1'b0; ch_resp_data = '0;
    step();
    chk("rst_ch_req_valid", 64'(ch_req_valid), 64'h0);
    chk("rst_req_grant", 64'(req_grant), 64'h0);
    chk("rst_outstanding", 64'(outstanding), 64'h0);
    chk("rst_err", 64'(err_orphan_resp), 64'h0);
    rst = 1'b0;

    // 1: single requester write burst
    for (int i = 0; i < 8; i++) begin
      req_addr[63:0] = 64'(i * 'h80);
      #1;
      chk("t1_grant", 64'(req_grant), 64'h1);
      chk("t1_addr", ch_req_addr, 64'(i * 'h80));
      step();
    end
    chk("t1_outstanding", 64'(outstanding), 64'h0);

    // req3 write moves rr_ptr from 1 through the wrap back to 0
    req_valid = 4'b1000;
    #1;
    chk("wrap_grant", 64'(req_grant), 64'h8);
    step();

    // 2: fairness between req0 and req1
    idx0 = 0; idx1 = 0;
    for (int c = 0; c < 16; c++) begin
      req_valid = {2'b00, idx1 < 8, idx0 < 8};
      req_data[31:0]    = 32'hDEAD0000 + 32'(idx0);
      req_data[543:512] = 32'hBEEF0000 + 32'(idx1);
      #1;
      chk("t2_grant", 64'(req_grant), 64'(1 << (c % 2)));
      chk("t2_data", 64'(ch_req_data[31:0]),
          (c % 2 == 0) ? 64'(32'hDEAD0000 + 32'(idx0)) : 64'(32'hBEEF0000 + 32'(idx1)));
      if (c % 2 == 0) idx0++; else idx1++;
      step();
    end
    req_valid = 4'b0000;
    #1;
    chk("t2_idle", 64'(ch_req_valid), 64'h0);

    // 3: in-order responses with stall
    req_is_write = 4'b0000;
    req_valid = 4'b0010; req_addr[127:64] = 64'h800;
    #1;
    chk("t3_grant1", 64'(req_grant), 64'h2);
    chk("t3_addr1", ch_req_addr, 64'h800);
    step();
    req_valid = 4'b0001; req_addr[63:0] = 64'h0;
    #1;
    chk("t3_grant0", 64'(req_grant), 64'h1);
    chk("t3_out1", 64'(outstanding), 64'h1);
    step();
    req_valid = 4'b0000;
    chk("t3_out2", 64'(outstanding), 64'h2);
    ch_resp_valid = 1'b1; ch_resp_data[63:0] = 64'hD1D1_D1D1_D1D1_D1D1; resp_grant = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("t3_stall_valid", 64'(resp_valid), 64'h2);
      chk("t3_stall_grant", 64'(ch_resp_grant), 64'h0);
      step();
    end
    resp_grant = 4'b0010;
    #1;
    chk("t3_d1_data", resp_data[63:0], 64'hD1D1_D1D1_D1D1_D1D1);
    chk("t3_d1_grant", 64'(ch_resp_grant), 64'h1);
    step();
    ch_resp_data[63:0] = 64'hD0D0_D0D0_D0D0_D0D0; resp_grant = 4'b0001;
    #1;
    chk("t3_d0_valid", 64'(resp_valid), 64'h1);
    chk("t3_d0_data", resp_data[63:0], 64'hD0D0_D0D0_D0D0_D0D0);
    step();
    ch_resp_valid = 1'b0; resp_grant = 4'b0000;
    #1;
    chk("t3_out0", 64'(outstanding), 64'h0);

    // 4: tag FIFO full
    req_valid = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t4_fill_grant", 64'(req_grant), 64'h1);
      step();
    end
    chk("t4_out16", 64'(outstanding), 64'h10);
    #1;
    chk("t4_read_blocked", 64'(ch_req_valid), 64'h0);
    req_valid = 4'b0101; req_is_write = 4'b0100;
    #1;
    chk("t4_write_grant", 64'(req_grant), 64'h4);
    step();
    req_valid = 4'b0001; req_is_write = 4'b0000;
    ch_resp_valid = 1'b1; resp_grant = 4'b0001;
    #1;
    chk("t4_resp_valid", 64'(resp_valid), 64'h1);
    chk("t4_no_same_cycle", 64'(req_grant), 64'h0);
    step();
    ch_resp_valid = 1'b0;
    #1;
    chk("t4_out15", 64'(outstanding), 64'hF);
    chk("t4_read_again", 64'(req_grant), 64'h1);
    step();
    req_valid = 4'b0000; ch_resp_valid = 1'b1;
    for (int i = 0; i < 16; i++) step();
    ch_resp_valid = 1'b0; resp_grant = 4'b0000;
    #1;
    chk("t4_drained", 64'(outstanding), 64'h0);

    // 5: disabled requester auto-drain
    req_valid = 4'b1000;
    step();
    step();
    chk("t5_out2", 64'(outstanding), 64'h2);
    req_enable = 4'b0111;
    #1;
    chk("t5_no_grant", 64'(ch_req_valid), 64'h0);
    req_valid = 4'b0000; ch_resp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t5_resp_valid", 64'(resp_valid), 64'h0);
      chk("t5_ch_grant", 64'(ch_resp_grant), 64'h1);
      step();
    end
    ch_resp_valid = 1'b0; req_enable = 4'hF;
    #1;
    chk("t5_out0", 64'(outstanding), 64'h0);

    // 6: orphan response, then reset mid-burst
    chk("t6_err_before", 64'(err_orphan_resp), 64'h0);
    ch_resp_valid = 1'b1;
    #1;
    chk("t6_orphan_grant", 64'(ch_resp_grant), 64'h1);
    chk("t6_orphan_valid", 64'(resp_valid), 64'h0);
    step();
    ch_resp_valid = 1'b0;
    chk("t6_err_set", 64'(err_orphan_resp), 64'h1);
    req_valid = 4'b0010;
    step();
    step();
    chk("t6_out2", 64'(outstanding), 64'h2);
    ch_resp_valid = 1'b1; resp_grant = 4'b0010;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_out", 64'(outstanding), 64'h0);
    chk("t6_rst_req_grant", 64'(req_grant), 64'h0);
    chk("t6_rst_ch_req_valid", 64'(ch_req_valid), 64'h0);
    chk("t6_rst_resp_valid", 64'(resp_valid), 64'h0);
    chk("t6_rst_ch_resp_grant", 64'(ch_resp_grant), 64'h0);
    chk("t6_rst_err", 64'(err_orphan_resp), 64'h0);
    step();
    rst = 1'b0; ch_resp_valid = 1'b0; resp_grant = 4'b0000;
    req_valid = 4'b0110; req_is_write = 4'b0110;
    #1;
    chk("t6_rr_ptr0", 64'(req_grant), 64'h2);
    chk("t6_out_after", 64'(outstanding), 64'h0);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
